multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle RISC-V main control unit. It replaces the single-cycle combinational opcode decoder with a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB.
- It handshakes with a variable-latency unified memory through mem_ready, times out stalled accesses, and traps on illegal opcodes.
- It sits between the instruction register and the shared datapath: PC, register file, ALU, and memory port.

Parameters:
SUPPORT_JUMP, 1, 1 enables JAL/JALR/LUI/AUIPC; 0 treats those opcodes as illegal
MEM_TIMEOUT, 16, max consecutive wait cycles per memory access before fault; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  load PC (PC+4 in FETCH, ALU target on jump)
ir_write  out  1  load instruction register and latch old PC / link value
alu_src_a  out  2  00 PC, 01 rs1, 10 old PC, 11 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
result_src  out  2  00 ALU, 01 memory data, 10 link (old PC+4)
branch  out  1  conditional PC update using ALU zero (EXEC of BR)
jump  out  1  PC loads ALU result (EXEC of JAL/JALR)
illegal_instr  out  1  sticky: illegal opcode trapped
mem_fault  out  1  sticky: memory timeout trapped
state  out  3  current state encoding, for debug

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Synchronous reset: state <= FETCH, opcode register and wait counter cleared, sticky flags cleared.
- While reset is high, every output is 0.
- Reset mid-operation aborts the instruction at the next edge; nothing is written after that edge.
- Outputs are Moore-decoded from state and the latched opcode, op_q. Unlisted outputs are 0.
- FETCH: mem_read=1, a=PC, b=4, alu_op=00. On the cycle mem_ready=1: ir_write=1, pc_write=1, then go to DECODE.
- DECODE: op_q <= opcode.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 BR.
  - With SUPPORT_JUMP=1, also legal: 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Legal opcode goes to EXEC. Anything else sets illegal_instr and goes to TRAP.
- EXEC, by op_q:
  - R: a=rs1, b=rs2, op=10, then WB.
  - I: a=rs1, b=imm, op=10, then WB.
  - LW/SW: a=rs1, b=imm, op=00, then MEM.
  - BR: a=rs1, b=rs2, op=01, branch=1, then FETCH.
  - JAL: a=old PC, b=imm, jump=1, pc_write=1, then WB.
  - JALR: same as JAL with a=rs1.
  - LUI: a=zero, b=imm, then WB.
  - AUIPC: a=old PC, b=imm, then WB.
- MEM: mem_read=1 for LW, mem_write=1 for SW, each held until mem_ready=1. Then LW goes to WB and SW goes to FETCH.
- WB: reg_write=1. result_src is 01 for LW, 10 for JAL/JALR, 00 otherwise. Then FETCH.
- Latency with mem_ready tied high: BR 3 cycles; R/I/SW/LUI/AUIPC/JAL/JALR 4; LW 5.
- Wait counter:
  - Width $clog2(MEM_TIMEOUT+1).
  - Counts cycles spent in FETCH or MEM with mem_ready=0.
  - Clears on mem_ready=1 and on every state change.
  - At count==MEM_TIMEOUT with mem_ready still 0: set mem_fault, go to TRAP.
  - mem_ready=1 on the same cycle the limit is reached wins; no fault.
- TRAP: all control outputs 0, sticky flag held, state stays TRAP until reset.
- state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams
  - state_t enum
  - alu_op, alu_src_a, alu_src_b and result_src encodings
- Sub-module mem_wait_timer (param MEM_TIMEOUT; inputs clk, reset, clear, waiting; output expired) holds the wait counter.

Test Plan:
- ADD (0110011), mem_ready=1: states 0,1,2,4,0. reg_write=1 only in cycle 4 with result_src=00; alu_op=10 in EXEC.
- LW, mem_ready low 3 cycles in MEM: mem_read held 4 MEM cycles. WB has reg_write=1, result_src=01. 8 cycles total. No fault.
- SW then BEQ: SW gives mem_write=1 in MEM, reg_write never 1. BEQ gives branch=1, alu_op=01 in EXEC and returns to FETCH after 3 cycles.
- JAL, SUPPORT_JUMP=1: EXEC has jump=1, pc_write=1, a=10, b=01. WB has result_src=10. With SUPPORT_JUMP=0: illegal_instr=1, state=5.
- Opcode 1111111: TRAP after DECODE, illegal_instr sticky 20 cycles. Reset pulse returns to FETCH with flags cleared.
- mem_ready=0 forever in FETCH, MEM_TIMEOUT=4: mem_fault=1 and TRAP after 4 wait cycles. Separately, reset asserted mid-MEM yields all outputs 0, then FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, FSM states and datapath select encodings for the
// multi-cycle RISC-V main control unit.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_LINK = 2'b10;

    function automatic logic is_legal(input logic [6:0] op, input logic support_jump);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR:       is_legal = 1'b1;
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:     is_legal = support_jump;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the allowed
// number of waits has been used up while memory is still not ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (waiting && count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    // A timeout of zero leaves the counter parked at zero and never expires.
    assign expired = (MEM_TIMEOUT != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM main control for a multi-cycle RISC-V datapath with memory
// handshake, access timeout and illegal-opcode trap.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_JUMP = 1'b1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       branch,
    output logic       jump,
    output logic       illegal_instr,
    output logic       mem_fault,
    output logic [2:0] state
);

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic       illegal_q, fault_q;
    logic       waiting, timer_clear, expired;

    assign waiting     = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign timer_clear = mem_ready || (state_d != state_q);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .waiting (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                if (!is_legal(opcode, SUPPORT_JUMP)) illegal_q <= 1'b1;
            end
            if (expired) fault_q <= 1'b1;
        end
    end

    // NOTE: every output and state_d gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALU;
        branch        = 1'b0;
        jump          = 1'b0;
        illegal_instr = illegal_q;
        mem_fault     = fault_q;
        state         = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = is_legal(opcode, SUPPORT_JUMP) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_BRANCH;
                        branch    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        alu_src_a = (op_q == OP_JAL) ? SRC_A_OLD_PC : SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                        jump      = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LUI: begin
                        alu_src_a = SRC_A_ZERO;
                        alu_src_b = SRC_B_IMM;
                        state_d   = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a = SRC_A_OLD_PC;
                        alu_src_b = SRC_B_IMM;
                        state_d   = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q != OP_LW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LW)                         result_src = RES_MEM;
                else if (op_q == OP_JAL || op_q == OP_JALR) result_src = RES_LINK;
                state_d = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase

        // Reset silences the whole interface, including the debug state.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            alu_src_a     = '0;
            alu_src_b     = '0;
            alu_op        = '0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            result_src    = '0;
            branch        = 1'b0;
            jump          = 1'b0;
            illegal_instr = 1'b0;
            mem_fault     = 1'b0;
            state         = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: walks each instruction class through the controller and
// compares the packed control word against hand-derived values every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;

    logic       pc_write, ir_write, mem_read, mem_write, reg_write, branch, jump;
    logic       illegal_instr, mem_fault;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] state;

    logic       pc_write2, ir_write2, mem_read2, mem_write2, reg_write2, branch2, jump2;
    logic       illegal_instr2, mem_fault2;
    logic [1:0] alu_src_a2, alu_src_b2, alu_op2, result_src2;
    logic [2:0] state2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.SUPPORT_JUMP(1'b1), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .branch(branch), .jump(jump), .illegal_instr(illegal_instr),
        .mem_fault(mem_fault), .state(state)
    );

    multicycle_controller #(.SUPPORT_JUMP(1'b0), .MEM_TIMEOUT(16)) dut_nojump (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write2), .ir_write(ir_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .mem_read(mem_read2),
        .mem_write(mem_write2), .reg_write(reg_write2), .result_src(result_src2),
        .branch(branch2), .jump(jump2), .illegal_instr(illegal_instr2),
        .mem_fault(mem_fault2), .state(state2)
    );

    // Packed control word: pcw irw a b op mr mw rw rs br j ill mf state
    wire [19:0] obs1 = {pc_write, ir_write, alu_src_a, alu_src_b, alu_op, mem_read,
                        mem_write, reg_write, result_src, branch, jump,
                        illegal_instr, mem_fault, state};
    wire [19:0] obs2 = {pc_write2, ir_write2, alu_src_a2, alu_src_b2, alu_op2, mem_read2,
                        mem_write2, reg_write2, result_src2, branch2, jump2,
                        illegal_instr2, mem_fault2, state2};

    function automatic logic [19:0] ov(input int pcw, irw, a, b, op, mr, mw, rw,
                                       input int rs, br, j, ill, mf, st);
        ov = {pcw[0], irw[0], a[1:0], b[1:0], op[1:0], mr[0], mw[0], rw[0],
              rs[1:0], br[0], j[0], ill[0], mf[0], st[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed=%05h expected=%05h", tag, observed, expected);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [19:0] expected);
        #2;
        chk(tag, obs1, expected);
        adv();
    endtask

    logic [19:0] f_rdy, f_wait, dec, ex_r, ex_addr, ex_br, ex_jal;
    logic [19:0] mem_rd, mem_wr, wb_alu, wb_mem, wb_link, trap_ill, trap_flt, zero;

    initial begin
        f_rdy    = ov(1,1,0,2,0,1,0,0,0,0,0,0,0,0);
        f_wait   = ov(0,0,0,2,0,1,0,0,0,0,0,0,0,0);
        dec      = ov(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        ex_r     = ov(0,0,1,0,2,0,0,0,0,0,0,0,0,2);
        ex_addr  = ov(0,0,1,1,0,0,0,0,0,0,0,0,0,2);
        ex_br    = ov(0,0,1,0,1,0,0,0,0,1,0,0,0,2);
        ex_jal   = ov(1,0,2,1,0,0,0,0,0,0,1,0,0,2);
        mem_rd   = ov(0,0,0,0,0,1,0,0,0,0,0,0,0,3);
        mem_wr   = ov(0,0,0,0,0,0,1,0,0,0,0,0,0,3);
        wb_alu   = ov(0,0,0,0,0,0,0,1,0,0,0,0,0,4);
        wb_mem   = ov(0,0,0,0,0,0,0,1,1,0,0,0,0,4);
        wb_link  = ov(0,0,0,0,0,0,0,1,2,0,0,0,0,4);
        trap_ill = ov(0,0,0,0,0,0,0,0,0,0,0,1,0,5);
        trap_flt = ov(0,0,0,0,0,0,0,0,0,0,0,0,1,5);
        zero     = '0;

        reset = 1'b1; opcode = '0; mem_ready = 1'b1;
        adv();
        step("reset_outputs", zero);
        reset = 1'b0;

        // ADD with memory always ready
        opcode = 7'b0110011;
        step("add_fetch", f_rdy);
        step("add_decode", dec);
        step("add_exec", ex_r);
        step("add_wb", wb_alu);

        // LW with three wait cycles in MEM
        opcode = 7'b0000011;
        step("lw_fetch", f_rdy);
        step("lw_decode", dec);
        step("lw_exec", ex_addr);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", mem_rd);
        mem_ready = 1'b1;
        step("lw_mem_done", mem_rd);
        step("lw_wb", wb_mem);

        // SW then BEQ
        opcode = 7'b0100011;
        step("sw_fetch", f_rdy);
        step("sw_decode", dec);
        step("sw_exec", ex_addr);
        step("sw_mem", mem_wr);
        opcode = 7'b1100011;
        step("beq_fetch", f_rdy);
        step("beq_decode", dec);
        step("beq_exec", ex_br);

        // JAL; the no-jump instance traps on the same opcode
        opcode = 7'b1101111;
        step("jal_fetch", f_rdy);
        step("jal_decode", dec);
        #1 chk("nojump_jal_trap", obs2, trap_ill);
        step("jal_exec", ex_jal);
        step("jal_wb", wb_link);

        // Illegal opcode: trap and hold
        opcode = 7'b1111111;
        step("ill_fetch", f_rdy);
        step("ill_decode", dec);
        for (int i = 0; i < 20; i++) step("ill_sticky", trap_ill);
        reset = 1'b1;
        step("ill_reset", zero);
        reset = 1'b0;

        // Ready arrives exactly at the wait limit: no fault
        opcode = 7'b0110011;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("limit_fetch_wait", f_wait);
        mem_ready = 1'b1;
        step("limit_fetch_ready", f_rdy);
        step("limit_decode", dec);
        step("limit_exec", ex_r);
        step("limit_wb", wb_alu);

        // Memory never ready in FETCH: fault after the limit
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("timeout_fetch_wait", f_wait);
        step("timeout_trap", trap_flt);
        step("timeout_hold", trap_flt);

        // Reset in the middle of a load's MEM phase
        reset = 1'b1;
        step("pre_lw_reset", zero);
        reset = 1'b0; mem_ready = 1'b1; opcode = 7'b0000011;
        step("rlw_fetch", f_rdy);
        step("rlw_decode", dec);
        step("rlw_exec", ex_addr);
        mem_ready = 1'b0;
        step("rlw_mem", mem_rd);
        reset = 1'b1;
        step("rlw_reset_mid_mem", zero);
        reset = 1'b0; mem_ready = 1'b1;
        step("rlw_after_reset", f_rdy);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
